// File: rtl/adc_frame_driver.sv
// Parallel-interface frame driver for a simultaneous-sampling multi-channel ADC.
// Sequences reset/convert/BUSY handshake/readout and emits one tagged sample per channel.
module adc_frame_driver #(
   parameter int NUM_CH      = 8,
   parameter int DATA_W      = 16,
   parameter int RST_CYC     = 5,
   parameter int CONV_CYC    = 2,
   parameter int RD_LOW_CYC  = 3,
   parameter int RD_HIGH_CYC = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int PERIOD_CYC  = 2000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont_en,
   input  logic              busy,
   input  logic [DATA_W-1:0] db,
   output logic [3:0]        convst,
   output logic              cs_n,
   output logic              rd_n,
   output logic              adc_rst,
   output logic              stby_n,
   output logic              par_n,
   output logic [DATA_W-1:0] sample_data,
   output logic [2:0]        sample_ch,
   output logic              sample_valid,
   output logic              frame_done,
   output logic              timeout_err,
   output logic              overrun,
   output logic              idle
);

   localparam int M0      = (RST_CYC > CONV_CYC) ? RST_CYC : CONV_CYC;
   localparam int M1      = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
   localparam int M2      = (M0 > M1) ? M0 : M1;
   localparam int CNT_MAX = (M2 > TIMEOUT_CYC) ? M2 : TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int P_W     = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

   typedef enum logic [2:0] {
      S_RST_ADC, S_IDLE, S_CONV, S_WAIT_HI, S_WAIT_LO, S_RD_L, S_RD_H
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       ch, ch_nx;
   logic [P_W-1:0]   pcnt;
   logic             prun;
   logic             tick;
   logic             mode_cont;
   logic             busy_m, busy_s;
   logic             trig, drop, capture, to_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_m <= 1'b0;
         busy_s <= 1'b0;
      end else begin
         busy_m <= busy;
         busy_s <= busy_m;
      end
   end

   // Period counter starts on the first IDLE after reset and never stops, so
   // free-running frames stay on a fixed grid regardless of frame length.
   assign tick = prun && (pcnt == P_W'(PERIOD_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt      <= '0;
         prun      <= 1'b0;
         mode_cont <= 1'b0;
      end else begin
         if (prun || state == S_IDLE) begin
            prun <= 1'b1;
            pcnt <= tick ? '0 : pcnt + 1'b1;
         end
         if (state == S_IDLE) mode_cont <= cont_en;
      end
   end

   assign trig = cont_en ? tick : start;
   // Triggers are only meaningful once the ADC reset sequence has finished.
   assign drop = (state != S_IDLE) && (state != S_RST_ADC) && (start || (mode_cont && tick));

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      ch_nx    = ch;
      capture  = 1'b0;
      to_evt   = 1'b0;
      case (state)
         // cnt is held at 0 while rst is high, so this counts RST_CYC cycles after release
         S_RST_ADC: if (cnt == CNT_W'(RST_CYC)) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
         S_IDLE: begin
            cnt_nx = '0;
            if (trig) begin
               state_nx = S_CONV;
               ch_nx    = '0;
            end
         end
         S_CONV: if (cnt == CNT_W'(CONV_CYC - 1)) begin
            state_nx = S_WAIT_HI;
            cnt_nx   = '0;
         end
         S_WAIT_HI: begin
            if (busy_s) begin
               state_nx = S_WAIT_LO;
               cnt_nx   = '0;
            end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_nx = S_IDLE;
               to_evt   = 1'b1;
            end
         end
         S_WAIT_LO: begin
            if (!busy_s) begin
               state_nx = S_RD_L;
               cnt_nx   = '0;
            end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_nx = S_IDLE;
               to_evt   = 1'b1;
            end
         end
         S_RD_L: if (cnt == CNT_W'(RD_LOW_CYC - 1)) begin
            capture  = 1'b1;
            state_nx = S_RD_H;
            cnt_nx   = '0;
         end
         S_RD_H: if (cnt == CNT_W'(RD_HIGH_CYC - 1)) begin
            cnt_nx = '0;
            if (ch == 3'(NUM_CH - 1)) begin
               state_nx = S_IDLE;
            end else begin
               state_nx = S_RD_L;
               ch_nx    = ch + 3'd1;
            end
         end
         default: begin
            state_nx = S_RST_ADC;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_RST_ADC;
         cnt          <= '0;
         ch           <= '0;
         sample_data  <= '0;
         sample_ch    <= '0;
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;
         timeout_err  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         ch           <= ch_nx;
         sample_valid <= capture;
         if (capture) begin
            sample_data <= db;
            sample_ch   <= ch;
         end
         frame_done  <= sample_valid && (sample_ch == 3'(NUM_CH - 1));
         timeout_err <= to_evt;
         overrun     <= drop;
      end
   end

   assign convst  = (state == S_CONV) ? 4'h0 : 4'hF;
   assign cs_n    = !((state == S_RD_L) || (state == S_RD_H));
   assign rd_n    = (state != S_RD_L);
   assign adc_rst = (state == S_RST_ADC);
   assign idle    = (state == S_IDLE);
   assign stby_n  = 1'b1;
   assign par_n   = 1'b0;

endmodule

// File: tb/tb_adc_frame_driver.sv
// Directed bench for adc_frame_driver with a small behavioural ADC (BUSY + data bus) model.
module tb_adc_frame_driver;

   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 16;
   localparam int BUSY_LEN = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              cont_en;
   logic              busy = 1'b0;
   logic [DATA_W-1:0] db = '0;
   logic [3:0]        convst;
   logic              cs_n, rd_n, adc_rst, stby_n, par_n;
   logic [DATA_W-1:0] sample_data;
   logic [2:0]        sample_ch;
   logic              sample_valid, frame_done, timeout_err, overrun, idle;

   int checks   = 0;
   int failures = 0;
   int adc_mode = 0;  // 0 responds normally, 1 BUSY stuck low, 2 BUSY stuck high

   adc_frame_driver #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RST_CYC(5), .CONV_CYC(2),
      .RD_LOW_CYC(3), .RD_HIGH_CYC(2), .TIMEOUT_CYC(16), .PERIOD_CYC(200)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cont_en(cont_en), .busy(busy), .db(db),
      .convst(convst), .cs_n(cs_n), .rd_n(rd_n), .adc_rst(adc_rst), .stby_n(stby_n),
      .par_n(par_n), .sample_data(sample_data), .sample_ch(sample_ch),
      .sample_valid(sample_valid), .frame_done(frame_done), .timeout_err(timeout_err),
      .overrun(overrun), .idle(idle)
   );

   always #5 clk = ~clk;

   // ADC model: BUSY rises 3 cycles after CONVST rises, stays high BUSY_LEN cycles;
   // each rd_n fall presents 0x1000 + word index on db.
   logic conv_q = 1'b1;
   logic rd_q   = 1'b1;
   int   bdelay = 0;
   int   bhold  = 0;
   int   rd_idx = 0;
   always @(negedge clk) begin
      if (adc_mode == 2) begin
         busy = 1'b1; bdelay = 0; bhold = 0;
      end else if (adc_mode == 1) begin
         busy = 1'b0; bdelay = 0; bhold = 0;
      end else begin
         if (bdelay > 0) begin
            bdelay--;
            if (bdelay == 0) bhold = BUSY_LEN;
         end else if (bhold > 0) begin
            bhold--;
         end
         busy = (bhold > 0);
         if (!conv_q && convst[0]) bdelay = 3;
      end
      if (conv_q && !convst[0]) rd_idx = 0;
      if (rd_q && !rd_n) begin
         db = 16'h1000 + 16'(rd_idx);
         rd_idx++;
      end
      conv_q = convst[0];
      rd_q   = rd_n;
   end

   task automatic test_reset();
      int n_rst;
      rst = 1'b1; start = 1'b0; cont_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (adc_rst !== 1'b1) begin failures++; $display("FAIL reset_adc_rst got=%b exp=1", adc_rst); end
      checks++; if (convst !== 4'hF) begin failures++; $display("FAIL reset_convst got=%h exp=f", convst); end
      checks++; if ({cs_n, rd_n, stby_n, par_n} !== 4'b1110) begin failures++; $display("FAIL reset_pins got=%b exp=1110", {cs_n, rd_n, stby_n, par_n}); end
      checks++; if ({sample_valid, frame_done, timeout_err, overrun, idle} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {sample_valid, frame_done, timeout_err, overrun, idle}); end
      checks++; if (sample_data !== 16'h0 || sample_ch !== 3'd0) begin failures++; $display("FAIL reset_sample got=%h/%0d exp=0/0", sample_data, sample_ch); end
      rst = 1'b0;
      n_rst = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (adc_rst) n_rst++;
      end
      checks++; if (n_rst != 5) begin failures++; $display("FAIL reset_len got=%0d exp=5", n_rst); end
      checks++; if (idle !== 1'b1 || convst !== 4'hF || cs_n !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b/%h/%b exp=1/f/1", idle, convst, cs_n); end
   endtask

   task automatic test_single_frame();
      int t = -1, nv = 0, nfd = 0, tfd = -1, tfirst = -1, tlast = -1, conv_lo = 0, cs_lo = 0;
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (convst != 4'hF) conv_lo++;
         if (t >= 0) t++;
         else if (conv_lo > 0 && convst == 4'hF) t = 0;
         if (!cs_n) cs_lo++;
         if (sample_valid) begin
            checks++; if (sample_ch !== 3'(nv) || sample_data !== 16'h1000 + 16'(nv)) begin
               failures++; $display("FAIL frame_word%0d got=%0d/%h exp=%0d/%h", nv, sample_ch, sample_data, nv, 16'h1000 + 16'(nv));
            end
            if (nv == 0) tfirst = t;
            else begin
               checks++; if (t - tlast != 5) begin failures++; $display("FAIL frame_spacing got=%0d exp=5", t - tlast); end
            end
            tlast = t;
            nv++;
         end
         if (frame_done) begin nfd++; tfd = t; end
         @(negedge clk);
      end
      checks++; if (conv_lo != 2) begin failures++; $display("FAIL frame_convst_len got=%0d exp=2", conv_lo); end
      checks++; if (nv != 4) begin failures++; $display("FAIL frame_nsamples got=%0d exp=4", nv); end
      checks++; if (tfirst != 19) begin failures++; $display("FAIL frame_first_lat got=%0d exp=19", tfirst); end
      checks++; if (nfd != 1 || tfd != tlast + 1) begin failures++; $display("FAIL frame_done got=%0d@%0d exp=1@%0d", nfd, tfd, tlast + 1); end
      checks++; if (cs_lo != 20) begin failures++; $display("FAIL frame_cs_len got=%0d exp=20", cs_lo); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL frame_idle got=%b exp=1", idle); end
   endtask

   // Shared by both stuck-BUSY scenarios; exp_t is measured from the first cycle after CONVST rises.
   task automatic test_busy_timeout(input int mode, input int exp_t);
      int t = -1, nto = 0, tto = -1, nsv = 0, nrd = 0, conv_lo = 0;
      logic idle_at_to = 1'b0;
      adc_mode = mode;
      repeat (4) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (convst != 4'hF) conv_lo++;
         if (t >= 0) t++;
         else if (conv_lo > 0 && convst == 4'hF) t = 0;
         if (timeout_err) begin
            nto++;
            if (tto < 0) begin tto = t; idle_at_to = idle; end
         end
         if (sample_valid || frame_done) nsv++;
         if (!rd_n) nrd++;
         @(negedge clk);
      end
      checks++; if (tto != exp_t) begin failures++; $display("FAIL timeout%0d_time got=%0d exp=%0d", mode, tto, exp_t); end
      checks++; if (nto != 1) begin failures++; $display("FAIL timeout%0d_count got=%0d exp=1", mode, nto); end
      checks++; if (idle_at_to !== 1'b1) begin failures++; $display("FAIL timeout%0d_idle got=%b exp=1", mode, idle_at_to); end
      checks++; if (nsv != 0) begin failures++; $display("FAIL timeout%0d_samples got=%0d exp=0", mode, nsv); end
      checks++; if (nrd != 0) begin failures++; $display("FAIL timeout%0d_rd got=%0d exp=0", mode, nrd); end
      adc_mode = 0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_free_run();
      int fall[3];
      int nfall = 0, nov = 0, nsv = 0;
      logic prev_hi = 1'b1;
      cont_en = 1'b1;
      for (int k = 0; k < 650; k++) begin
         start = (nfall == 2 && k == fall[1] + 10);
         if (prev_hi && convst == 4'h0 && nfall < 3) begin fall[nfall] = k; nfall++; end
         prev_hi = (convst == 4'hF);
         if (overrun) nov++;
         if (sample_valid && nfall < 3) nsv++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (nfall != 3) begin failures++; $display("FAIL free_nframes got=%0d exp=3", nfall); end
      else begin
         checks++; if (fall[1] - fall[0] != 200) begin failures++; $display("FAIL free_period1 got=%0d exp=200", fall[1] - fall[0]); end
         checks++; if (fall[2] - fall[1] != 200) begin failures++; $display("FAIL free_period2 got=%0d exp=200", fall[2] - fall[1]); end
      end
      checks++; if (nov != 1) begin failures++; $display("FAIL free_overrun got=%0d exp=1", nov); end
      checks++; if (nsv != 8) begin failures++; $display("FAIL free_samples got=%0d exp=8", nsv); end
      for (int k = 0; k < 100 && !idle; k++) @(negedge clk);
      cont_en = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 100 && !idle; k++) @(negedge clk);
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL free_stop_idle got=%b exp=1", idle); end
   endtask

   task automatic test_reset_mid_read();
      int nv = 0, nstrobe = 0, n_rst = 0;
      logic hit = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         if (sample_valid) nv++;
         if (nv == 2 && !rd_n) hit = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!hit) begin failures++; $display("FAIL midrst_reach got=0 exp=1"); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({cs_n, rd_n, adc_rst} !== 3'b111) begin failures++; $display("FAIL midrst_pins got=%b exp=111", {cs_n, rd_n, adc_rst}); end
      checks++; if ({sample_valid, frame_done, idle} !== 3'b000 || convst !== 4'hF) begin failures++; $display("FAIL midrst_strobes got=%b/%h exp=000/f", {sample_valid, frame_done, idle}, convst); end
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (adc_rst) n_rst++;
         if (sample_valid || frame_done) nstrobe++;
      end
      checks++; if (n_rst != 5) begin failures++; $display("FAIL midrst_adc_rst_len got=%0d exp=5", n_rst); end
      checks++; if (nstrobe != 0) begin failures++; $display("FAIL midrst_late_strobes got=%0d exp=0", nstrobe); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_busy_timeout(1, 16);
      test_busy_timeout(2, 17);
      test_free_run();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
